// File: rtl/sd_sector_buf.sv
// sd_sector_buf -- sequential multi-sector fetch engine with ping-pong buffer.
//
// Requests sectors one at a time from sd_read16, captures each 16-bit word
// stream into one of two banks, and drains full banks as a byte-wide
// AXI-stream so consumer backpressure never stalls the SD side.
//
// Ports:
//   sd_clk, sd_rst_n        clock, synchronous active-low reset
//   sdinit_ok               card ready; requests are held off while low
//   start, start_sector,
//   sector_count            job launch (accepted only while not busy)
//   busy, done, err_len     job status; err_len is sticky per job
//   addr_TVALID, addr       one-cycle sector request to sd_read16
//   SectorData_*            incoming word stream (no ready)
//   m_TVALID/TDATA/TLAST,
//   m_TREADY                outgoing byte stream, high byte of each word first
//   sector_cksum,
//   cksum_valid             per-sector word sum (SD_SECTOR_BUF_CKSUM_EN)
//
// Optional feature macro: SD_SECTOR_BUF_CKSUM_EN. When undefined the checksum
// outputs are tied to zero.
// WORDS_PER_SECTOR must be a power of two (bank index is concatenated).
`timescale 1ns/1ps
module sd_sector_buf #(
    parameter int unsigned WORDS_PER_SECTOR = 256,
    parameter logic [31:0] ADDR_STEP        = 32'd1
) (
    input  logic        sd_clk,
    input  logic        sd_rst_n,
    input  logic        sdinit_ok,
    input  logic        start,
    input  logic [31:0] start_sector,
    input  logic [15:0] sector_count,
    output logic        busy,
    output logic        done,
    output logic        err_len,
    output logic        addr_TVALID,
    output logic [31:0] addr,
    input  logic        SectorData_TVALID,
    input  logic [15:0] SectorData_TDATA,
    input  logic        SectorData_TLAST,
    output logic        m_TVALID,
    output logic [7:0]  m_TDATA,
    output logic        m_TLAST,
    input  logic        m_TREADY,
    output logic [15:0] sector_cksum,
    output logic        cksum_valid
);

    localparam int unsigned AW = $clog2(WORDS_PER_SECTOR);
    localparam int unsigned CW = $clog2(WORDS_PER_SECTOR + 1);
    localparam logic [CW-1:0] WPS = CW'(WORDS_PER_SECTOR);

    typedef enum logic [1:0] {W_IDLE, W_REQ, W_CAP, W_COMMIT} wstate_t;
    wstate_t w_state, w_next;

    logic [15:0]   mem [2*WORDS_PER_SECTOR];
    logic [15:0]   req_left, rd_left;
    logic [31:0]   next_addr;
    logic          wr_bank, rf_bank, out_bank;
    logic [CW-1:0] wr_idx, rf_idx;
    logic [1:0]    bank_full, fetched;
    logic [CW-1:0] bank_cnt [2];
    logic          nxt_v, nxt_last, cur_v, cur_last, half;
    logic [15:0]   nxt_word, cur_word;

    logic start_ok, cap_word, cap_fits, cap_wr;
    logic out_hs, tlast_hs, cur_load, fetch, fetch_last;

    assign start_ok   = start && !busy;
    assign cap_word   = (w_state == W_CAP) && SectorData_TVALID;
    assign cap_fits   = wr_idx < WPS;
    assign cap_wr     = cap_word && cap_fits;

    // Two-stage read path: nxt_word is the registered RAM output, cur_word
    // feeds the byte mux. A new RAM read is issued whenever nxt is empty or is
    // being moved into cur, so a word is always ready when cur's low byte goes.
    assign out_hs     = cur_v && m_TREADY;
    assign tlast_hs   = out_hs && half && cur_last;
    assign cur_load   = nxt_v && (!cur_v || (out_hs && half));
    assign fetch      = bank_full[rf_bank] && !fetched[rf_bank] && (!nxt_v || cur_load);
    assign fetch_last = (rf_idx + CW'(1)) == bank_cnt[rf_bank];

    assign m_TVALID = cur_v;
    assign m_TDATA  = half ? cur_word[7:0] : cur_word[15:8];
    assign m_TLAST  = cur_v && half && cur_last;

    always_ff @(posedge sd_clk) begin
        if (!sd_rst_n) w_state <= W_IDLE;
        else           w_state <= w_next;
    end

    always_comb begin
        w_next      = w_state;
        addr_TVALID = 1'b0;
        addr        = '0;
        case (w_state)
            W_IDLE:   if (busy && req_left != 16'd0 && !bank_full[wr_bank] && sdinit_ok)
                          w_next = W_REQ;
            W_REQ: begin
                addr_TVALID = 1'b1;
                addr        = next_addr;
                w_next      = W_CAP;
            end
            W_CAP:    if (SectorData_TVALID && SectorData_TLAST) w_next = W_COMMIT;
            W_COMMIT: w_next = W_IDLE;
            default:  w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge sd_clk) begin
        if (cap_wr) mem[{wr_bank, wr_idx[AW-1:0]}] <= SectorData_TDATA;
        if (fetch)  nxt_word <= mem[{rf_bank, rf_idx[AW-1:0]}];
    end

    always_ff @(posedge sd_clk) begin
        if (!sd_rst_n) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            err_len   <= 1'b0;
            req_left  <= '0;
            rd_left   <= '0;
            next_addr <= '0;
            wr_bank   <= 1'b0;
            rf_bank   <= 1'b0;
            out_bank  <= 1'b0;
            wr_idx    <= '0;
            rf_idx    <= '0;
            bank_full <= '0;
            fetched   <= '0;
            bank_cnt  <= '{default: '0};
            nxt_v     <= 1'b0;
            nxt_last  <= 1'b0;
            cur_v     <= 1'b0;
            cur_last  <= 1'b0;
            cur_word  <= '0;
            half      <= 1'b0;
        end else begin
            done <= 1'b0;

            if (start_ok) begin
                err_len   <= 1'b0;
                req_left  <= sector_count;
                rd_left   <= sector_count;
                next_addr <= start_sector;
                wr_bank   <= 1'b0;
                rf_bank   <= 1'b0;
                out_bank  <= 1'b0;
                wr_idx    <= '0;
                rf_idx    <= '0;
                fetched   <= '0;
                if (sector_count == 16'd0) done <= 1'b1;
                else                       busy <= 1'b1;
            end

            if (w_state == W_REQ) begin
                next_addr <= next_addr + ADDR_STEP;
                req_left  <= req_left - 16'd1;
            end

            if (cap_word) begin
                if (cap_fits) wr_idx  <= wr_idx + CW'(1);
                else          err_len <= 1'b1;
                // short sector: count after this word is still below a full sector
                if (SectorData_TLAST && wr_idx < WPS - CW'(1)) err_len <= 1'b1;
            end

            if (w_state == W_COMMIT) begin
                bank_full[wr_bank] <= 1'b1;
                bank_cnt[wr_bank]  <= wr_idx;
                wr_bank            <= ~wr_bank;
                wr_idx             <= '0;
            end

            if (fetch) begin
                nxt_v    <= 1'b1;
                nxt_last <= fetch_last;
                if (fetch_last) begin
                    fetched[rf_bank] <= 1'b1;
                    rf_bank          <= ~rf_bank;
                    rf_idx           <= '0;
                end else begin
                    rf_idx <= rf_idx + CW'(1);
                end
            end else if (cur_load) begin
                nxt_v <= 1'b0;
            end

            if (out_hs) begin
                if (!half) begin
                    half <= 1'b1;
                end else begin
                    half <= 1'b0;
                    if (!cur_load) cur_v <= 1'b0;
                end
            end

            if (cur_load) begin
                cur_v    <= 1'b1;
                cur_word <= nxt_word;
                cur_last <= nxt_last;
            end

            if (tlast_hs) begin
                bank_full[out_bank] <= 1'b0;
                fetched[out_bank]   <= 1'b0;
                out_bank            <= ~out_bank;
                rd_left             <= rd_left - 16'd1;
                if (rd_left == 16'd1) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

`ifdef SD_SECTOR_BUF_CKSUM_EN
    logic [15:0] sum;

    always_ff @(posedge sd_clk) begin
        if (!sd_rst_n) begin
            sum          <= '0;
            sector_cksum <= '0;
            cksum_valid  <= 1'b0;
        end else begin
            cksum_valid <= 1'b0;
            if (cap_wr) sum <= sum + SectorData_TDATA;
            if (w_state == W_COMMIT) begin
                sector_cksum <= sum;
                cksum_valid  <= 1'b1;
                sum          <= '0;
            end
        end
    end
`else
    assign sector_cksum = '0;
    assign cksum_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_sd_sector_buf.sv
// Directed bench for sd_sector_buf: an SD-side responder pushes expected bytes
// into a scoreboard as it drives words; the consumer pops and compares.
`timescale 1ns/1ps
module tb_sd_sector_buf;

    logic        sd_clk = 1'b0;
    logic        sd_rst_n, sdinit_ok, start;
    logic [31:0] start_sector;
    logic [15:0] sector_count;
    logic        busy, done, err_len, addr_TVALID;
    logic [31:0] addr;
    logic        SectorData_TVALID, SectorData_TLAST;
    logic [15:0] SectorData_TDATA;
    logic        m_TVALID, m_TLAST;
    logic        m_TREADY = 1'b0;
    logic [7:0]  m_TDATA;
    logic [15:0] sector_cksum;
    logic        cksum_valid;

    int          n_err = 0;
    int          n_chk = 0;
    logic [8:0]  exp_q[$];
    logic [31:0] exp_addr[$];
    int          len_q[$];
    int          req_total = 0;
    int          done_cnt = 0;
    int          ck_cnt = 0;
    logic [15:0] ck_last = '0;
    int          rdy_mode = 0;
    bit          word_mode = 1'b0;
    logic [15:0] seq_base = '0;

    always #5 sd_clk = ~sd_clk;

    sd_sector_buf #(.WORDS_PER_SECTOR(256), .ADDR_STEP(32'd1)) dut (
        .sd_clk(sd_clk), .sd_rst_n(sd_rst_n), .sdinit_ok(sdinit_ok),
        .start(start), .start_sector(start_sector), .sector_count(sector_count),
        .busy(busy), .done(done), .err_len(err_len),
        .addr_TVALID(addr_TVALID), .addr(addr),
        .SectorData_TVALID(SectorData_TVALID), .SectorData_TDATA(SectorData_TDATA),
        .SectorData_TLAST(SectorData_TLAST),
        .m_TVALID(m_TVALID), .m_TDATA(m_TDATA), .m_TLAST(m_TLAST), .m_TREADY(m_TREADY),
        .sector_cksum(sector_cksum), .cksum_valid(cksum_valid)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // SD responder: checks each request address, then streams len words.
    initial begin
        int          len;
        logic [15:0] w;
        logic [31:0] ea;
        SectorData_TVALID = 1'b0;
        SectorData_TDATA  = '0;
        SectorData_TLAST  = 1'b0;
        forever begin
            @(negedge sd_clk);
            if (sd_rst_n && addr_TVALID) begin
                req_total++;
                if (exp_addr.size() == 0) begin
                    check("addr_expected", 64'(exp_addr.size()), 64'd1);
                end else begin
                    ea = exp_addr.pop_front();
                    check("addr", 64'(addr), 64'(ea));
                end
                len = (len_q.size() != 0) ? len_q.pop_front() : 256;
                for (int i = 0; i < len; i++) begin
                    @(negedge sd_clk);
                    if (i == 0) check("addr_pulse_1cyc", 64'(addr_TVALID), 64'd0);
                    w = word_mode ? 16'h0101 : 16'(seq_base + 16'(i) + 16'd1);
                    SectorData_TVALID = 1'b1;
                    SectorData_TDATA  = w;
                    SectorData_TLAST  = (i == len - 1);
                    exp_q.push_back({1'b0, w[15:8]});
                    exp_q.push_back({(i == len - 1), w[7:0]});
                end
                @(negedge sd_clk);
                SectorData_TVALID = 1'b0;
                SectorData_TLAST  = 1'b0;
                seq_base = seq_base + 16'h0300;
            end
        end
    end

    // Consumer: sets m_TREADY for the coming edge, then scores any handshake.
    initial begin
        logic       stall_prev;
        logic [8:0] held, e;
        stall_prev = 1'b0;
        held = '0;
        forever begin
            @(negedge sd_clk);
            case (rdy_mode)
                0:       m_TREADY = 1'b1;
                1:       m_TREADY = ~m_TREADY;
                default: m_TREADY = 1'b0;
            endcase
            if (stall_prev)
                check("stall_hold", 64'({m_TVALID, m_TLAST, m_TDATA}), 64'({1'b1, held}));
            if (m_TVALID && m_TREADY) begin
                if (exp_q.size() == 0) begin
                    check("byte_expected", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("byte", 64'({m_TLAST, m_TDATA}), 64'(e));
                end
                stall_prev = 1'b0;
            end else begin
                stall_prev = m_TVALID;
                held = {m_TLAST, m_TDATA};
            end
        end
    end

    initial begin
        forever begin
            @(negedge sd_clk);
            if (done) begin
                done_cnt++;
                check("busy_low_with_done", 64'(busy), 64'd0);
            end
            if (cksum_valid) begin
                ck_cnt++;
                ck_last = sector_cksum;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog expired errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1, "watchdog");
    end

    task automatic start_job(input logic [31:0] s, input logic [15:0] c);
        start_sector = s;
        sector_count = c;
        start = 1'b1;
        @(negedge sd_clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int max_cyc);
        int n = 0;
        while (done_cnt < target && n < max_cyc) begin
            @(negedge sd_clk);
            n++;
        end
        check("done_count", 64'(done_cnt), 64'(target));
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        check("addr_q_drained", 64'(exp_addr.size()), 64'd0);
    endtask

    task automatic wait_reqs(input int target, input int max_cyc);
        int n = 0;
        while (req_total < target && n < max_cyc) begin
            @(negedge sd_clk);
            n++;
        end
        check("req_reached", 64'(req_total), 64'(target));
    endtask

    initial begin
        int base, ck0;
        sd_rst_n = 1'b0; sdinit_ok = 1'b0; start = 1'b0;
        start_sector = '0; sector_count = '0;
        repeat (3) @(negedge sd_clk);
        check("reset_outputs", 64'({busy, done, err_len, addr_TVALID, m_TVALID, m_TLAST,
                                    m_TDATA, cksum_valid, sector_cksum}), 64'd0);
        check("reset_addr", 64'(addr), 64'd0);
        sd_rst_n = 1'b1;
        @(negedge sd_clk);

        // one sector, held off by sdinit_ok
        exp_addr.push_back(32'd0);
        start_job(32'd0, 16'd1);
        check("busy_after_start", 64'(busy), 64'd1);
        repeat (5) @(negedge sd_clk);
        check("no_req_before_init", 64'(req_total), 64'd0);
        sdinit_ok = 1'b1;
        wait_done(1, 3000);
        check("err_len_clean", 64'(err_len), 64'd0);

        // three sectors with consumer stalled: third request must wait
        base = req_total;
        exp_addr.push_back(32'd16); exp_addr.push_back(32'd17); exp_addr.push_back(32'd18);
        rdy_mode = 2;
        start_job(32'd16, 16'd3);
        wait_reqs(base + 2, 2000);
        repeat (300) @(negedge sd_clk);
        check("third_req_withheld", 64'(req_total), 64'(base + 2));
        check("valid_while_stalled", 64'(m_TVALID), 64'd1);
        rdy_mode = 0;
        wait_done(2, 5000);
        check("third_req_issued", 64'(req_total), 64'(base + 3));
        repeat (5) @(negedge sd_clk);
        check("done_once", 64'(done_cnt), 64'd2);

        // ready toggling every cycle
        exp_addr.push_back(32'd100); exp_addr.push_back(32'd101);
        rdy_mode = 1;
        start_job(32'd100, 16'd2);
        wait_done(3, 6000);
        rdy_mode = 0;

        // short first sector
        len_q.push_back(100); len_q.push_back(256);
        exp_addr.push_back(32'd40); exp_addr.push_back(32'd41);
        start_job(32'd40, 16'd2);
        wait_done(4, 4000);
        check("err_len_short", 64'(err_len), 64'd1);

        // address wrap, start while busy ignored
        base = req_total;
        exp_addr.push_back(32'hFFFF_FFFF); exp_addr.push_back(32'h0000_0000);
        start_job(32'hFFFF_FFFF, 16'd2);
        check("err_len_cleared", 64'(err_len), 64'd0);
        repeat (3) @(negedge sd_clk);
        start_job(32'h0000_1234, 16'd5);
        wait_done(5, 4000);
        repeat (5) @(negedge sd_clk);
        check("busy_start_ignored", 64'(req_total), 64'(base + 2));

        // zero-length job
        base = req_total;
        start_job(32'd7, 16'd0);
        check("zero_done", 64'(done), 64'd1);
        check("zero_busy", 64'(busy), 64'd0);
        @(negedge sd_clk);
        check("zero_done_pulse", 64'(done), 64'd0);
        repeat (3) @(negedge sd_clk);
        check("zero_no_req", 64'(req_total), 64'(base));

        // constant-word sector for the checksum path
        ck0 = ck_cnt;
        word_mode = 1'b1;
        exp_addr.push_back(32'h500);
        start_job(32'h500, 16'd1);
        wait_done(7, 3000);
        word_mode = 1'b0;
`ifdef SD_SECTOR_BUF_CKSUM_EN
        check("cksum_pulses", 64'(ck_cnt), 64'(ck0 + 1));
        check("cksum_value", 64'(ck_last), 64'h0100);
`else
        check("cksum_pulses_off", 64'(ck_cnt), 64'(ck0));
        check("cksum_value_off", 64'(sector_cksum), 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
